// File: rtl/encoder_gate_ctrl_if.sv
// encoder_gate_ctrl_if: encoder input, window request/acknowledge and result bus
interface encoder_gate_ctrl_if;
    logic       a;
    logic [3:0] in_sel;
    logic       start;
    logic       ack;
    logic [7:0] count;
    logic       valid;
    logic       busy;
    logic       ovf;
    modport master (output a, in_sel, start, ack, input count, valid, busy, ovf);
    modport slave (input a, in_sel, start, ack, output count, valid, busy, ovf);
endinterface

// File: rtl/encoder_gate_ctrl.sv
// encoder_gate_ctrl: gated encoder edge counter; ENC_BOTH_EDGE_EN counts both edges of A, default rising only
module encoder_gate_ctrl (
    input  logic               clk_i,
    input  logic               rst_i,
    encoder_gate_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GATE, HOLD} state_t;
    state_t      state_q, state_d;
    logic        a_meta_q, a_sync_q, a_prev_q;
    logic [15:0] win_q, win_d;
    logic [7:0]  edge_q, edge_d, edge_nx;
    logic [7:0]  count_q, count_d;
    logic        ovf_flag_q, ovf_flag_d, ovf_flag_nx;
    logic        ovf_q, ovf_d;
    logic        valid_q, valid_d;
    logic        edge_det, edge_sat, load;
`ifdef ENC_BOTH_EDGE_EN
    assign edge_det = a_sync_q ^ a_prev_q;
`else
    assign edge_det = a_sync_q & ~a_prev_q;
`endif
    assign edge_sat    = edge_q == 8'hFF;
    assign edge_nx     = (edge_det && !edge_sat) ? edge_q + 8'd1 : edge_q;
    assign ovf_flag_nx = ovf_flag_q | (edge_det & edge_sat);
    assign load        = bus.start && (state_q == IDLE || (state_q == HOLD && bus.ack));
    // two-flop synchronizer for A plus a delayed copy for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_meta_q <= 1'b0;
            a_sync_q <= 1'b0;
            a_prev_q <= 1'b0;
        end else begin
            a_meta_q <= bus.a;
            a_sync_q <= a_meta_q;
            a_prev_q <= a_sync_q;
        end
    end
    // state, window/edge counters and latched result registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            win_q      <= '0;
            edge_q     <= '0;
            ovf_flag_q <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            edge_q     <= edge_d;
            ovf_flag_q <= ovf_flag_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end
    // next state: load a window on an accepted start, count through GATE, latch at window end
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        edge_d     = edge_q;
        ovf_flag_d = ovf_flag_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        valid_d    = valid_q;
        if (load) begin
            state_d    = GATE;
            win_d      = {bus.in_sel, 12'hFFF};
            edge_d     = '0;
            ovf_flag_d = 1'b0;
            valid_d    = 1'b0;
        end else if (state_q == GATE) begin
            win_d      = win_q - 16'd1;
            edge_d     = edge_nx;
            ovf_flag_d = ovf_flag_nx;
            if (win_q == 16'd0) begin
                state_d = HOLD;
                count_d = edge_nx;
                ovf_d   = ovf_flag_nx;
                valid_d = 1'b1;
            end
        end else if (state_q == HOLD && bus.ack) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end
    assign bus.count = count_q;
    assign bus.valid = valid_q;
    assign bus.busy  = state_q == GATE;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_encoder_gate_ctrl.sv
// tb_encoder_gate_ctrl: directed checks of gating, saturation, hold handshake and reset
module tb_encoder_gate_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int passed = 0;
    int total = 0;
`ifdef ENC_BOTH_EDGE_EN
    localparam int EXP_BASIC = 16;
    localparam int EXP_IN1   = 9;
`else
    localparam int EXP_BASIC = 8;
    localparam int EXP_IN1   = 5;
`endif
    encoder_gate_ctrl_if bus ();
    encoder_gate_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic gate_run(input int period, input int offset, input int evt, input int budget,
                            output int busy_n, output int lat);
        busy_n = 0;
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            if (period > 0 && i >= offset && (i - offset) % period == 0) bus.a = ~bus.a;
            if (i == evt) begin bus.in_sel = 4'hF; bus.ack = 1'b1; bus.start = 1'b1; end
            if (i == evt + 1) begin bus.ack = 1'b0; bus.start = 1'b0; end
            if (bus.valid) begin lat = i; break; end
            if (bus.busy) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic start_window(input logic [3:0] sel);
        @(negedge clk);
        bus.in_sel = sel;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        int bad = 0;
        #50;
        total++;
        if ({bus.count, bus.valid, bus.busy, bus.ovf} !== 11'd0) $display("FAIL reset_in: outs=%h want 0", {bus.count, bus.valid, bus.busy, bus.ovf});
        else passed++;
        #50 rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ({bus.count, bus.valid, bus.busy, bus.ovf} !== 11'd0) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL reset_idle: nonzero samples=%0d want 0", bad);
        else passed++;
    endtask

    task automatic test_basic_window();
        int busy_n, lat;
        start_window(4'd0);
        gate_run(256, 100, -10, 5000, busy_n, lat);
        total++;
        if (lat !== 4096) $display("FAIL basic_latency: got %0d want 4096", lat);
        else passed++;
        total++;
        if (busy_n !== 4096) $display("FAIL basic_busy: got %0d want 4096", busy_n);
        else passed++;
        total++;
        if (bus.count !== 8'(EXP_BASIC)) $display("FAIL basic_count: got %0d want %0d", bus.count, EXP_BASIC);
        else passed++;
        total++;
        if (bus.ovf !== 1'b0 || bus.busy !== 1'b0) $display("FAIL basic_flags: ovf=%b busy=%b want 0 0", bus.ovf, bus.busy);
        else passed++;
    endtask

    task automatic test_hold_start();
        int bad_v = 0, bad_c = 0, bad_b = 0;
        for (int j = 0; j < 1000; j++) begin
            bus.start = (j == 500);
            @(negedge clk);
            if (bus.valid !== 1'b1) bad_v++;
            if (bus.count !== 8'(EXP_BASIC)) bad_c++;
            if (bus.busy !== 1'b0) bad_b++;
        end
        bus.start = 1'b0;
        total++;
        if (bad_v !== 0) $display("FAIL hold_valid: dropped samples=%0d want 0", bad_v);
        else passed++;
        total++;
        if (bad_c !== 0) $display("FAIL hold_count: changed samples=%0d want 0", bad_c);
        else passed++;
        total++;
        if (bad_b !== 0) $display("FAIL hold_busy: busy samples=%0d want 0", bad_b);
        else passed++;
        bus.in_sel = 4'd0;
        bus.ack = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        bus.start = 1'b0;
        total++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b1) $display("FAIL back_to_back: valid=%b busy=%b want 0 1", bus.valid, bus.busy);
        else passed++;
    endtask

    task automatic test_in_change();
        int busy_n, lat;
        gate_run(0, 0, 10, 70000, busy_n, lat);
        total++;
        if (lat !== 4096) $display("FAIL in_change_latency: got %0d want 4096", lat);
        else passed++;
        total++;
        if (bus.count !== 8'd0 || bus.ovf !== 1'b0) $display("FAIL in_change_result: count=%0d ovf=%b want 0 0", bus.count, bus.ovf);
        else passed++;
    endtask

    task automatic test_ack_to_idle(input logic [7:0] held);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        total++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL ack_idle: valid=%b busy=%b want 0 0", bus.valid, bus.busy);
        else passed++;
        repeat (10) @(negedge clk);
        total++;
        if (bus.count !== held || bus.valid !== 1'b0) $display("FAIL ack_hold_count: count=%0d valid=%b want %0d 0", bus.count, bus.valid, held);
        else passed++;
    endtask

    task automatic test_overflow();
        int busy_n, lat;
        bus.a = 1'b0;
        repeat (5) @(negedge clk);
        start_window(4'd0);
        gate_run(4, 10, -10, 5000, busy_n, lat);
        total++;
        if (lat !== 4096) $display("FAIL ovf_latency: got %0d want 4096", lat);
        else passed++;
        total++;
        if (bus.count !== 8'd255 || bus.ovf !== 1'b1) $display("FAIL ovf_result: count=%0d ovf=%b want 255 1", bus.count, bus.ovf);
        else passed++;
        bus.a = 1'b0;
        test_ack_to_idle(8'd255);
        total++;
        if (bus.ovf !== 1'b1) $display("FAIL ovf_hold: ovf=%b want 1", bus.ovf);
        else passed++;
    endtask

    task automatic test_reset_mid_gate();
        int bad = 0;
        repeat (5) @(negedge clk);
        start_window(4'd0);
        repeat (2000) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({bus.count, bus.valid, bus.busy, bus.ovf} !== 11'd0) $display("FAIL reset_async: outs=%h want 0", {bus.count, bus.valid, bus.busy, bus.ovf});
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4200; i++) begin
            @(negedge clk);
            if ({bus.count, bus.valid, bus.busy, bus.ovf} !== 11'd0) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL reset_no_valid: nonzero samples=%0d want 0", bad);
        else passed++;
    endtask

    task automatic test_reset_release_start();
        int busy_n, lat;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_sel = 4'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1) $display("FAIL release_start: busy=%b want 1", bus.busy);
        else passed++;
        gate_run(1000, 50, -10, 9000, busy_n, lat);
        total++;
        if (lat !== 8192 || busy_n !== 8192) $display("FAIL in1_window: latency=%0d busy=%0d want 8192 8192", lat, busy_n);
        else passed++;
        total++;
        if (bus.count !== 8'(EXP_IN1) || bus.ovf !== 1'b0) $display("FAIL in1_result: count=%0d ovf=%b want %0d 0", bus.count, bus.ovf, EXP_IN1);
        else passed++;
    endtask

    initial begin
        bus.a = 1'b0;
        bus.in_sel = 4'd0;
        bus.start = 1'b0;
        bus.ack = 1'b0;
        test_reset();
        test_basic_window();
        test_hold_start();
        test_in_change();
        test_ack_to_idle(8'd0);
        test_overflow();
        test_reset_mid_gate();
        test_reset_release_start();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/encoder_gate_ctrl.md
ENCODER_GATE_CTRL -- requirements
Module: encoder_gate_ctrl

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 RST  input  1  reset; asynchronous, active-high.
REQ-003 A  input  1  encoder channel; asynchronous to CLK.
REQ-004 IN  input  4  window select; gate length = (IN+1)*4096 CLK cycles.
REQ-005 START  input  1  single-cycle request to begin one measurement.
REQ-006 ACK  input  1  consumer acknowledge of a latched result.
REQ-007 Count  output  8  edge count of the last completed window.
REQ-008 VALID  output  1  Count holds an unacknowledged new result.
REQ-009 BUSY  output  1  a gate window is in progress.
REQ-010 OVF  output  1  the last latched window saturated.

Function
REQ-011 The block SHALL pass A through a two-flop synchronizer, then detect edges by comparing against a third registered copy; an A transition SHALL be counted no later than 3 CLK cycles after it occurs.
REQ-012 The block SHALL implement three states: IDLE, GATE, HOLD.
REQ-013 IDLE: BUSY=0; on START=1 the block SHALL capture IN, load the 16-bit window counter with (IN+1)*4096-1, clear the 8-bit edge counter and the overflow flag, and enter GATE next cycle.
REQ-014 GATE: BUSY=1; each detected edge SHALL increment the edge counter; the window counter SHALL decrement once per cycle.
REQ-015 The edge counter SHALL saturate at 255; a detected edge while at 255 SHALL set the internal overflow flag and leave the counter at 255.
REQ-016 When the window counter is 0 in GATE, the block SHALL, on that clock edge, load Count with the edge count (including an edge detected that same cycle), load OVF with the overflow flag, set VALID=1, and enter HOLD.
REQ-017 HOLD: BUSY=0, VALID=1 until ACK=1; on ACK the block SHALL clear VALID on the next edge and return to IDLE.
REQ-018 ACK and START both high in HOLD SHALL clear VALID and start a new window directly (HOLD->GATE), applying REQ-013 actions.
REQ-019 START in GATE or in HOLD without ACK SHALL be ignored; ACK outside HOLD SHALL be ignored.
REQ-020 Changes on IN after capture SHALL NOT affect the running window.
REQ-021 Count and OVF SHALL hold their values until the next latch in REQ-016.

Reset
REQ-022 While RST=1: state=IDLE, Count=0, VALID=0, BUSY=0, OVF=0, all counters and synchronizer flops=0.
REQ-023 RST asserted mid-GATE or mid-HOLD SHALL discard the measurement; no VALID pulse SHALL follow reset release.
REQ-024 After RST deasserts, the block SHALL accept START on the first rising edge of CLK.

Configuration
REQ-025 Macro ENC_BOTH_EDGE_EN defined: both rising and falling synchronized edges of A SHALL be counted.
REQ-026 Macro ENC_BOTH_EDGE_EN undefined: only rising edges of A SHALL be counted; all other behaviour identical.

Verification
REQ-027 RST=1 for 100 ns then released, no stimulus -> Count=0, VALID=0, BUSY=0, OVF=0 indefinitely.
REQ-028 IN=0, START pulse, A toggling every 256 cycles starting 100 cycles after START -> BUSY high 4096 cycles, then VALID=1, Count=8 (16 with ENC_BOTH_EDGE_EN), OVF=0.
REQ-029 IN=15, A toggling every 100 cycles -> window 65536 cycles, Count=255, OVF=1.
REQ-030 VALID=1, ACK held low 1000 cycles, START pulsed -> VALID stays 1, Count unchanged, BUSY stays 0; then ACK=1 with START=1 -> VALID=0 and BUSY=1 next cycle.
REQ-031 RST pulsed at cycle 2000 of an IN=0 window -> all outputs 0, no VALID afterwards without a new START.
REQ-032 IN changed from 0 to 15 at cycle 10 of an IN=0 window -> VALID still asserts after 4096 cycles.
